// File: rtl/io_input_fifo_if.sv
// Device-to-CPU input port bundle: device byte handshake, CPU read/clear strobes, and head/status readback.
interface io_input_fifo_if;
    logic [7:0] dev_data;
    logic       dev_valid;
    logic       dev_ready;
    logic       re;
    logic       clr_ovf;
    logic [7:0] port_data;
    logic [7:0] status;
    logic [2:0] count;

    modport master (
        output dev_data, dev_valid, re, clr_ovf,
        input  dev_ready, port_data, status, count
    );

    modport slave (
        input  dev_data, dev_valid, re, clr_ovf,
        output dev_ready, port_data, status, count
    );
endinterface

// File: rtl/io_input_fifo.sv
// Purpose: small circular byte buffer between an external device and a CPU IN port, with a sticky overflow flag.
// Latency: a byte pushed into an empty buffer is on port_data the cycle after the push edge.
// Backpressure: dev_ready drops when full; a byte offered while full is dropped and sets ovf.
module io_input_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          reset,
    io_input_fifo_if.slave bus
);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [2:0]       count;
    logic             ovf;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic ovf_set;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == 3'(DEPTH));
    assign empty   = (count == 3'd0);
    // Handshake depends only on registered occupancy, so a same-cycle read cannot open a slot.
    assign push    = bus.dev_valid && !full;
    assign pop     = bus.re && !empty;
    assign ovf_set = bus.dev_valid && full;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= 3'd0;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            // An overflow in the same edge as a clear leaves the flag set.
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wptr] <= bus.dev_data;
        end
    end

    assign bus.dev_ready = !full;
    assign bus.port_data = empty ? 8'h00 : 8'(mem[rptr]);
    assign bus.status    = {ovf, full, empty, 2'b00, count};
    assign bus.count     = count;

endmodule

// File: tb/tb_io_input_fifo.sv
module tb_io_input_fifo;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    io_input_fifo_if bus ();

    io_input_fifo #(.DEPTH(4), .WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dev_valid = 1'b0;
        bus.dev_data  = 8'h00;
        bus.re        = 1'b0;
        bus.clr_ovf   = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        bus.dev_valid = 1'b1;
        bus.dev_data  = d;
        step();
        idle();
    endtask

    task automatic pop();
        bus.re = 1'b1;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        bus.dev_valid = 1'b1;
        bus.dev_data  = 8'hEE;
        step();
        reset = 1'b0;
        idle();
        total++;
        if (bus.dev_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b exp=1", bus.dev_ready);
        end
        total++;
        if (bus.port_data !== 8'h00) begin
            bad++; $display("FAIL reset_port got=%h exp=00", bus.port_data);
        end
        total++;
        if (bus.status !== 8'h20) begin
            bad++; $display("FAIL reset_status got=%h exp=20", bus.status);
        end
        total++;
        if (bus.count !== 3'd0) begin
            bad++; $display("FAIL reset_count got=%0d exp=0", bus.count);
        end
    endtask

    task automatic test_single();
        push(8'hA5);
        total++;
        if (bus.port_data !== 8'hA5) begin
            bad++; $display("FAIL single_port got=%h exp=a5", bus.port_data);
        end
        total++;
        if (bus.count !== 3'd1) begin
            bad++; $display("FAIL single_count got=%0d exp=1", bus.count);
        end
        total++;
        if (bus.status !== 8'h01) begin
            bad++; $display("FAIL single_status got=%h exp=01", bus.status);
        end
        pop();
        total++;
        if (bus.status !== 8'h20) begin
            bad++; $display("FAIL single_pop_status got=%h exp=20", bus.status);
        end
    endtask

    task automatic test_fill();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        total++;
        if (bus.count !== 3'd4) begin
            bad++; $display("FAIL fill_count got=%0d exp=4", bus.count);
        end
        total++;
        if (bus.dev_ready !== 1'b0) begin
            bad++; $display("FAIL fill_ready got=%b exp=0", bus.dev_ready);
        end
        total++;
        if (bus.status !== 8'h44) begin
            bad++; $display("FAIL fill_status got=%h exp=44", bus.status);
        end
        push(8'h55);
        total++;
        if (bus.status !== 8'hC4) begin
            bad++; $display("FAIL overflow_status got=%h exp=c4", bus.status);
        end
        total++;
        if (bus.port_data !== 8'h11) begin
            bad++; $display("FAIL overflow_head got=%h exp=11", bus.port_data);
        end
    endtask

    task automatic test_ovf_set_wins();
        bus.dev_valid = 1'b1;
        bus.dev_data  = 8'h66;
        bus.clr_ovf   = 1'b1;
        step();
        idle();
        total++;
        if (bus.status !== 8'hC4) begin
            bad++; $display("FAIL set_wins_status got=%h exp=c4", bus.status);
        end
        bus.clr_ovf = 1'b1;
        step();
        idle();
        total++;
        if (bus.status !== 8'h44) begin
            bad++; $display("FAIL clr_ovf_status got=%h exp=44", bus.status);
        end
    endtask

    task automatic test_drain();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.port_data !== exp_q[i]) begin
                bad++; $display("FAIL drain_%0d got=%h exp=%h", i, bus.port_data, exp_q[i]);
            end
            pop();
        end
        total++;
        if (bus.port_data !== 8'h00) begin
            bad++; $display("FAIL drain_empty_port got=%h exp=00", bus.port_data);
        end
        total++;
        if (bus.status !== 8'h20) begin
            bad++; $display("FAIL drain_empty_status got=%h exp=20", bus.status);
        end
    endtask

    task automatic test_wrap();
        push(8'h01);
        push(8'h02);
        push(8'h03);
        pop();
        pop();
        push(8'h04);
        bus.dev_valid = 1'b1;
        bus.dev_data  = 8'h77;
        bus.re        = 1'b1;
        step();
        idle();
        total++;
        if (bus.count !== 3'd2) begin
            bad++; $display("FAIL wrap_count got=%0d exp=2", bus.count);
        end
        total++;
        if (bus.port_data !== 8'h04) begin
            bad++; $display("FAIL wrap_head0 got=%h exp=04", bus.port_data);
        end
        pop();
        total++;
        if (bus.port_data !== 8'h77) begin
            bad++; $display("FAIL wrap_head1 got=%h exp=77", bus.port_data);
        end
        pop();
        total++;
        if (bus.status !== 8'h20) begin
            bad++; $display("FAIL wrap_empty got=%h exp=20", bus.status);
        end
    endtask

    task automatic test_full_push_pop_and_reset();
        push(8'hC0);
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        bus.dev_valid = 1'b1;
        bus.dev_data  = 8'hEE;
        bus.re        = 1'b1;
        step();
        idle();
        total++;
        if (bus.status !== 8'h83) begin
            bad++; $display("FAIL full_rw_status got=%h exp=83", bus.status);
        end
        total++;
        if (bus.port_data !== 8'hC1) begin
            bad++; $display("FAIL full_rw_head got=%h exp=c1", bus.port_data);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (bus.count !== 3'd0) begin
            bad++; $display("FAIL midreset_count got=%0d exp=0", bus.count);
        end
        total++;
        if (bus.status !== 8'h20) begin
            bad++; $display("FAIL midreset_status got=%h exp=20", bus.status);
        end
        total++;
        if (bus.dev_ready !== 1'b1) begin
            bad++; $display("FAIL midreset_ready got=%b exp=1", bus.dev_ready);
        end
        total++;
        if (bus.port_data !== 8'h00) begin
            bad++; $display("FAIL midreset_port got=%h exp=00", bus.port_data);
        end
    endtask

    task automatic test_empty_passthrough();
        bus.dev_valid = 1'b1;
        bus.dev_data  = 8'h9C;
        bus.re        = 1'b1;
        step();
        idle();
        total++;
        if (bus.count !== 3'd1) begin
            bad++; $display("FAIL empty_rw_count got=%0d exp=1", bus.count);
        end
        total++;
        if (bus.port_data !== 8'h9C) begin
            bad++; $display("FAIL empty_rw_port got=%h exp=9c", bus.port_data);
        end
        pop();
        pop();
        total++;
        if (bus.status !== 8'h20) begin
            bad++; $display("FAIL empty_pop_status got=%h exp=20", bus.status);
        end
        total++;
        if (bus.port_data !== 8'h00) begin
            bad++; $display("FAIL empty_pop_port got=%h exp=00", bus.port_data);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle();
        test_reset();
        test_single();
        test_fill();
        test_ovf_set_wins();
        test_drain();
        test_wrap();
        test_full_push_pop_and_reset();
        test_empty_passthrough();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/io_input_fifo.md
IO_INPUT_FIFO -- requirements
Module: io_input_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered bytes; legal values 2 and 4 only.
REQ-002 Parameter WIDTH, default 8, data width; fixed at 8 for CPU port compatibility.
REQ-003 Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 clk  input  1  rising-edge clock shared with the CPU.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 dev_data  input  8  byte offered by the external device.
REQ-007 dev_valid  input  1  device asserts a byte is offered this cycle.
REQ-008 dev_ready  output  1  block accepts a byte this cycle.
REQ-009 re  input  1  CPU read strobe for this port: the IN instruction's decode selects this port.
REQ-010 clr_ovf  input  1  clears the sticky overflow flag.
REQ-011 port_data  output  8  head byte, driven to one of the CPU data input ports in_p0..in_p3.
REQ-012 status  output  8  status byte, driven to the matching extra input port ine_p0..ine_p3.
REQ-013 count  output  3  number of bytes held, range 0..DEPTH.

Function
REQ-014 Storage: DEPTH x 8 circular buffer with write pointer, read pointer and count register; pointers wrap DEPTH-1 -> 0.
REQ-015 dev_ready shall equal (count != DEPTH) and shall be derived from registered state only; it does not depend on re.
REQ-016 Push: when dev_valid=1 and dev_ready=1 at a rising edge, dev_data is written at the write pointer, and the write pointer and count increment.
REQ-017 Pop: when re=1 and count!=0 at a rising edge, the read pointer increments and count decrements.
REQ-018 Push and pop in the same edge (count not 0, not DEPTH): both pointers advance and count is unchanged.
REQ-019 Pop while empty is ignored; no state changes and no error flag.
REQ-020 Push while full (dev_valid=1, dev_ready=0): the byte is dropped, the buffer is unchanged, and ovf is set.
REQ-021 Full with re=1 and dev_valid=1: only the pop occurs, and ovf is set, because dev_ready was 0.
REQ-022 Empty with re=1 and dev_valid=1: only the push occurs, and the pushed byte is not consumed.
REQ-023 port_data shall be the entry at the read pointer when count!=0, and 8'h00 when count=0; it is combinational from registered state.
REQ-024 Latency: a byte pushed at edge N appears on port_data during the cycle after edge N, if the buffer was empty.
REQ-025 The CPU samples port_data in the same cycle it asserts re; the pop takes effect at the end of that cycle.
REQ-026 Status byte layout: bit7=ovf, bit6=full (count==DEPTH), bit5=empty (count==0), bits4:3=2'b00, bits2:0=count.
REQ-027 ovf is sticky. clr_ovf=1 clears it at the next edge. If an overflow and clr_ovf=1 occur in the same edge, ovf ends at 1 (set wins).
REQ-028 count is 3 bits; it never exceeds DEPTH or goes below 0 under any input combination.

Reset
REQ-029 While reset=1 at a rising edge: count=0, both pointers=0, ovf=0; all other inputs are ignored that edge.
REQ-030 After reset the outputs are: dev_ready=1, port_data=8'h00, status=8'h20, count=0.
REQ-031 Reset mid-operation discards all buffered bytes; buffer contents need not be cleared.
REQ-032 The block contains no asynchronous logic; all state changes on the rising edge of clk.

Verification
REQ-033 Reset, then push 8'hA5 for one cycle -> next cycle port_data=8'hA5, count=1, status=8'h01.
REQ-034 Push 8'h11, 8'h22, 8'h33, 8'h44 back-to-back -> count=4, dev_ready=0, status=8'h44; a fifth push of 8'h55 -> status=8'hC4 and port_data still 8'h11.
REQ-035 Full buffer, then four consecutive re pulses -> port_data reads 8'h11, 8'h22, 8'h33, 8'h44 in order, then 8'h00 and status=8'h20 (ovf cleared beforehand via clr_ovf).
REQ-036 count=2, simultaneous push of 8'h77 and re -> count stays 2 and the old head is removed; the pointer wrap past index 3 preserves order.
REQ-037 Empty, re=1 with dev_valid=1 and dev_data=8'h9C -> count=1, port_data=8'h9C; re on an empty buffer alone -> no change.
REQ-038 Three bytes buffered with ovf=1, assert reset one cycle -> count=0, status=8'h20, dev_ready=1, port_data=8'h00.
